// File: rtl/bfpu_ctrl.sv
// Instruction sequencer and bit-vector register file feeding an external bfpu.
// Accepts one instruction per IDLE visit, issues it for one cycle, then waits for the result.
module bfpu_ctrl #(
  parameter int unsigned BIT_VEC_SIZE = 256,
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned REG_ADDR_W   = 4,
  parameter int unsigned TIMEOUT      = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [2:0]              instr_opcode,
  input  logic                    instr_choice,
  input  logic [REG_ADDR_W-1:0]   instr_src1,
  input  logic [REG_ADDR_W-1:0]   instr_src2,
  input  logic [REG_ADDR_W-1:0]   instr_dst,
  input  logic                    wr_en,
  input  logic [REG_ADDR_W-1:0]   wr_addr,
  input  logic [BIT_VEC_SIZE-1:0] wr_data,
  input  logic [REG_ADDR_W-1:0]   rd_addr,
  output logic [BIT_VEC_SIZE-1:0] rd_data,
  output logic [BIT_VEC_SIZE-1:0] bfpu_in_1,
  output logic                    bfpu_valid_in_1,
  output logic [BIT_VEC_SIZE-1:0] bfpu_in_2,
  output logic                    bfpu_valid_in_2,
  output logic [2:0]              bfpu_opcode,
  output logic                    bfpu_choice,
  input  logic [BIT_VEC_SIZE-1:0] bfpu_out,
  input  logic                    bfpu_valid_out,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    accept, wb_en;
  logic [REG_ADDR_W-1:0]   dst_q;
  logic [BIT_VEC_SIZE-1:0] in1_q, in2_q, rd_data_q;
  logic [2:0]              opcode_q;
  logic                    choice_q;
  logic [BIT_VEC_SIZE-1:0] regs_q [NUM_REGS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    accept  = 1'b0;
    wb_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (instr_valid && instr_ready) begin
          if (instr_opcode <= 3'd4) begin
            accept  = 1'b1;
            state_d = StIssue;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (bfpu_valid_out) begin
          wb_en   = 1'b1;
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (cnt_q == CntLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      dst_q     <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      opcode_q  <= '0;
      choice_q  <= 1'b0;
      rd_data_q <= '0;
      regs_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_data_q <= regs_q[rd_addr];
      if (accept) begin
        in1_q    <= regs_q[instr_src1];
        in2_q    <= regs_q[instr_src2];
        opcode_q <= instr_opcode;
        choice_q <= instr_choice;
        dst_q    <= instr_dst;
      end
      if (wr_en) begin
        regs_q[wr_addr] <= wr_data;
      end
      // Ordered after the host write so writeback wins a same-address collision.
      if (wb_en) begin
        regs_q[dst_q] <= bfpu_out;
      end
    end
  end

  assign instr_ready     = (state_q == StIdle) && !rst;
  assign busy            = (state_q != StIdle);
  assign bfpu_valid_in_1 = (state_q == StIssue);
  assign bfpu_valid_in_2 = (state_q == StIssue);
  assign bfpu_in_1       = in1_q;
  assign bfpu_in_2       = in2_q;
  assign bfpu_opcode     = opcode_q;
  assign bfpu_choice     = choice_q;
  assign rd_data         = rd_data_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_bfpu_ctrl.sv
// Randomized self-checking bench for bfpu_ctrl; emulates bfpu and keeps an
// instruction-level register-file model.
module tb_bfpu_ctrl;

  localparam int W       = 256;
  localparam int TIMEOUT = 15;
  typedef logic [W-1:0] vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [2:0] instr_opcode = '0;
  logic       instr_choice = 1'b0;
  logic [3:0] instr_src1 = '0, instr_src2 = '0, instr_dst = '0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  vec_t       wr_data = '0;
  logic [3:0] rd_addr = '0;
  vec_t       rd_data;
  vec_t       bfpu_in_1, bfpu_in_2;
  logic       bfpu_valid_in_1, bfpu_valid_in_2;
  logic [2:0] bfpu_opcode;
  logic       bfpu_choice;
  vec_t       bfpu_out = '0;
  logic       bfpu_valid_out = 1'b0;
  logic       busy, done, err;

  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t mregs [16];

  bfpu_ctrl #(
    .BIT_VEC_SIZE(W),
    .NUM_REGS    (16),
    .REG_ADDR_W  (4),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_opcode   (instr_opcode),
    .instr_choice   (instr_choice),
    .instr_src1     (instr_src1),
    .instr_src2     (instr_src2),
    .instr_dst      (instr_dst),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .bfpu_in_1      (bfpu_in_1),
    .bfpu_valid_in_1(bfpu_valid_in_1),
    .bfpu_in_2      (bfpu_in_2),
    .bfpu_valid_in_2(bfpu_valid_in_2),
    .bfpu_opcode    (bfpu_opcode),
    .bfpu_choice    (bfpu_choice),
    .bfpu_out       (bfpu_out),
    .bfpu_valid_out (bfpu_valid_out),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_val(input string tag, input vec_t obs, input vec_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic vec_t bv_op(input logic [2:0] op, input logic ch, input vec_t a,
                                 input vec_t b);
    case (op)
      3'd0:    return ch ? b : a;
      3'd1:    return a | b;
      3'd2:    return a & b;
      3'd3:    return a & ~b;
      3'd4:    return a ^ b;
      default: return '0;
    endcase
  endfunction

  function automatic vec_t rand_vec();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic rand_host();
    wr_en   = ($urandom_range(0, 2) == 0);
    wr_addr = 4'($urandom());
    wr_data = rand_vec();
  endtask

  // One clock edge: model applies host write then writeback; rd_data must show pre-edge contents.
  task automatic step(input bit wb, input logic [3:0] wb_addr, input vec_t wb_val,
                      input int ra_sel);
    logic [3:0] ra;
    vec_t       exp_rd;
    ra      = (ra_sel < 0) ? 4'($urandom()) : 4'(ra_sel);
    rd_addr = ra;
    exp_rd  = mregs[ra];
    @(posedge clk); #1;
    if (wr_en) mregs[wr_addr] = wr_data;
    if (wb) mregs[wb_addr] = wb_val;
    wr_en = 1'b0;
    check_val("rd_data", rd_data, exp_rd);
  endtask

  task automatic read_chk(input string tag, input logic [3:0] addr, input vec_t exp);
    step(1'b0, 4'd0, '0, int'(addr));
    check_val(tag, rd_data, exp);
  endtask

  task automatic host_pre(input bit rnd, input int e, input int hw_at, input logic [3:0] hw_addr,
                          input vec_t hw_data);
    if (rnd) rand_host();
    if (e == hw_at) begin
      wr_en   = 1'b1;
      wr_addr = hw_addr;
      wr_data = hw_data;
    end
  endtask

  // lat: WAIT cycle (1 = nominal) on which bfpu answers; negative means never (timeout).
  task automatic exec(input logic [2:0] op, input logic ch, input logic [3:0] s1,
                      input logic [3:0] s2, input logic [3:0] d, input int lat, input bit rnd,
                      input int hw_at, input logic [3:0] hw_addr, input vec_t hw_data);
    vec_t a, b, exp_res, bf_res;
    int   e;
    e = 0;
    check_val("ready_idle", vec_t'(instr_ready), vec_t'(1'b1));
    a = mregs[s1];
    b = mregs[s2];
    instr_valid  = 1'b1;
    instr_opcode = op;
    instr_choice = ch;
    instr_src1   = s1;
    instr_src2   = s2;
    instr_dst    = d;
    host_pre(rnd, e, hw_at, hw_addr, hw_data); e++;
    step(1'b0, 4'd0, '0, -1);
    instr_valid  = 1'b0;
    instr_opcode = 3'($urandom());
    instr_choice = 1'($urandom());
    instr_src1   = 4'($urandom());
    instr_src2   = 4'($urandom());
    instr_dst    = 4'($urandom());
    if (op > 3'd4) begin
      check_val("illegal_err", vec_t'(err), vec_t'(1'b1));
      check_val("illegal_done", vec_t'(done), vec_t'(1'b0));
      check_val("illegal_v1", vec_t'(bfpu_valid_in_1), vec_t'(1'b0));
      check_val("illegal_v2", vec_t'(bfpu_valid_in_2), vec_t'(1'b0));
      check_val("illegal_busy", vec_t'(busy), vec_t'(1'b0));
      check_val("illegal_ready", vec_t'(instr_ready), vec_t'(1'b1));
      step(1'b0, 4'd0, '0, -1);
      check_val("illegal_err_pulse", vec_t'(err), vec_t'(1'b0));
      return;
    end
    check_val("issue_v1", vec_t'(bfpu_valid_in_1), vec_t'(1'b1));
    check_val("issue_v2", vec_t'(bfpu_valid_in_2), vec_t'(1'b1));
    check_val("issue_in1", bfpu_in_1, a);
    check_val("issue_in2", bfpu_in_2, b);
    check_val("issue_opcode", vec_t'(bfpu_opcode), vec_t'(op));
    check_val("issue_choice", vec_t'(bfpu_choice), vec_t'(ch));
    check_val("issue_busy", vec_t'(busy), vec_t'(1'b1));
    check_val("issue_ready", vec_t'(instr_ready), vec_t'(1'b0));
    check_val("issue_done", vec_t'(done), vec_t'(1'b0));
    check_val("issue_err", vec_t'(err), vec_t'(1'b0));
    bf_res  = bv_op(bfpu_opcode, bfpu_choice, bfpu_in_1, bfpu_in_2);
    exp_res = bv_op(op, ch, a, b);
    if (rnd) begin
      bfpu_valid_out = 1'($urandom());
      bfpu_out       = rand_vec();
    end
    host_pre(rnd, e, hw_at, hw_addr, hw_data); e++;
    step(1'b0, 4'd0, '0, -1);
    bfpu_valid_out = 1'b0;
    check_val("wait_v1", vec_t'(bfpu_valid_in_1), vec_t'(1'b0));
    check_val("wait_busy", vec_t'(busy), vec_t'(1'b1));
    check_val("wait_ready", vec_t'(instr_ready), vec_t'(1'b0));
    check_val("wait_opcode_hold", vec_t'(bfpu_opcode), vec_t'(op));
    check_val("wait_in1_hold", bfpu_in_1, a);
    if (lat < 0) begin
      for (int k = 0; k < TIMEOUT; k++) begin
        check_val("to_busy", vec_t'(busy), vec_t'(1'b1));
        check_val("to_err_early", vec_t'(err), vec_t'(1'b0));
        host_pre(rnd, e, hw_at, hw_addr, hw_data); e++;
        step(1'b0, 4'd0, '0, -1);
      end
      check_val("to_err", vec_t'(err), vec_t'(1'b1));
      check_val("to_done", vec_t'(done), vec_t'(1'b0));
      check_val("to_busy_end", vec_t'(busy), vec_t'(1'b0));
      check_val("to_ready", vec_t'(instr_ready), vec_t'(1'b1));
      step(1'b0, 4'd0, '0, -1);
      check_val("to_err_pulse", vec_t'(err), vec_t'(1'b0));
      return;
    end
    for (int k = 1; k < lat; k++) begin
      check_val("lat_busy", vec_t'(busy), vec_t'(1'b1));
      check_val("lat_done", vec_t'(done), vec_t'(1'b0));
      host_pre(rnd, e, hw_at, hw_addr, hw_data); e++;
      step(1'b0, 4'd0, '0, -1);
    end
    bfpu_valid_out = 1'b1;
    bfpu_out       = bf_res;
    host_pre(rnd, e, hw_at, hw_addr, hw_data); e++;
    step(1'b1, d, exp_res, -1);
    bfpu_valid_out = 1'b0;
    check_val("wb_done", vec_t'(done), vec_t'(1'b1));
    check_val("wb_err", vec_t'(err), vec_t'(1'b0));
    check_val("wb_busy", vec_t'(busy), vec_t'(1'b0));
    check_val("wb_ready", vec_t'(instr_ready), vec_t'(1'b1));
  endtask

  initial begin
    logic [2:0] op;
    int         lat;
    foreach (mregs[i]) mregs[i] = '0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("rst_ready", vec_t'(instr_ready), vec_t'(1'b0));
    check_val("rst_busy", vec_t'(busy), vec_t'(1'b0));
    check_val("rst_done", vec_t'(done), vec_t'(1'b0));
    check_val("rst_err", vec_t'(err), vec_t'(1'b0));
    check_val("rst_v1", vec_t'(bfpu_valid_in_1), vec_t'(1'b0));
    check_val("rst_in1", bfpu_in_1, '0);
    check_val("rst_rd", rd_data, '0);
    rst = 1'b0;
    step(1'b0, 4'd0, '0, -1);
    check_val("idle_ready", vec_t'(instr_ready), vec_t'(1'b1));

    wr_en = 1'b1; wr_addr = 4'd1; wr_data = vec_t'(16'hF0F0);
    step(1'b0, 4'd0, '0, -1);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = vec_t'(16'hFF00);
    step(1'b0, 4'd0, '0, -1);

    // OR with a colliding host write to r3 on the writeback edge
    exec(3'd1, 1'b0, 4'd1, 4'd2, 4'd3, 1, 1'b0, 2, 4'd3, vec_t'(16'h1234));
    read_chk("or_r3", 4'd3, vec_t'(16'hFFF0));
    // AND with a host write to r1 during WAIT
    exec(3'd2, 1'b0, 4'd1, 4'd2, 4'd3, 3, 1'b0, 2, 4'd1, vec_t'(16'hAAAA));
    read_chk("and_r3", 4'd3, vec_t'(16'hF000));
    read_chk("wait_wr_r1", 4'd1, vec_t'(16'hAAAA));
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = vec_t'(16'hF0F0);
    step(1'b0, 4'd0, '0, -1);
    exec(3'd3, 1'b0, 4'd1, 4'd2, 4'd3, 1, 1'b0, -1, 4'd0, '0);
    read_chk("andn_r3", 4'd3, vec_t'(16'h00F0));
    exec(3'd4, 1'b0, 4'd1, 4'd2, 4'd3, 1, 1'b0, -1, 4'd0, '0);
    read_chk("xor_r3", 4'd3, vec_t'(16'h0FF0));
    exec(3'd0, 1'b0, 4'd1, 4'd2, 4'd3, 1, 1'b0, -1, 4'd0, '0);
    read_chk("sel0_r3", 4'd3, vec_t'(16'hF0F0));
    exec(3'd0, 1'b1, 4'd1, 4'd2, 4'd3, 1, 1'b0, -1, 4'd0, '0);
    read_chk("sel1_r3", 4'd3, vec_t'(16'hFF00));
    exec(3'd5, 1'b0, 4'd1, 4'd2, 4'd3, 1, 1'b0, -1, 4'd0, '0);
    read_chk("illegal_r3", 4'd3, vec_t'(16'hFF00));
    read_chk("illegal_r1", 4'd1, vec_t'(16'hF0F0));
    exec(3'd1, 1'b0, 4'd1, 4'd2, 4'd3, -1, 1'b0, -1, 4'd0, '0);
    read_chk("timeout_r3", 4'd3, vec_t'(16'hFF00));

    for (int n = 0; n < 60; n++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        bfpu_valid_out = 1'($urandom());
        bfpu_out       = rand_vec();
        rand_host();
        step(1'b0, 4'd0, '0, -1);
        bfpu_valid_out = 1'b0;
        check_val("gap_done", vec_t'(done), vec_t'(1'b0));
        check_val("gap_err", vec_t'(err), vec_t'(1'b0));
        check_val("gap_busy", vec_t'(busy), vec_t'(1'b0));
      end
      op  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      lat = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(1, 4);
      exec(op, 1'($urandom()), 4'($urandom()), 4'($urandom()), 4'($urandom()), lat, 1'b1,
           -1, 4'd0, '0);
    end

    // Reset while in WAIT: instruction is abandoned
    instr_valid = 1'b1; instr_opcode = 3'd1; instr_src1 = 4'd1; instr_src2 = 4'd2;
    instr_dst = 4'd5;
    step(1'b0, 4'd0, '0, -1);
    instr_valid = 1'b0;
    step(1'b0, 4'd0, '0, -1);
    check_val("pre_rst_busy", vec_t'(busy), vec_t'(1'b1));
    rst = 1'b1;
    bfpu_valid_out = 1'b1;
    bfpu_out = '1;
    @(posedge clk); #1;
    check_val("mrst_ready", vec_t'(instr_ready), vec_t'(1'b0));
    check_val("mrst_busy", vec_t'(busy), vec_t'(1'b0));
    check_val("mrst_done", vec_t'(done), vec_t'(1'b0));
    check_val("mrst_err", vec_t'(err), vec_t'(1'b0));
    check_val("mrst_v1", vec_t'(bfpu_valid_in_1), vec_t'(1'b0));
    check_val("mrst_v2", vec_t'(bfpu_valid_in_2), vec_t'(1'b0));
    check_val("mrst_in1", bfpu_in_1, '0);
    check_val("mrst_in2", bfpu_in_2, '0);
    check_val("mrst_opcode", vec_t'(bfpu_opcode), '0);
    check_val("mrst_choice", vec_t'(bfpu_choice), '0);
    check_val("mrst_rd", rd_data, '0);
    bfpu_valid_out = 1'b0;
    rst = 1'b0;
    foreach (mregs[i]) mregs[i] = '0;
    step(1'b0, 4'd0, '0, -1);
    check_val("post_rst_done", vec_t'(done), vec_t'(1'b0));
    check_val("post_rst_ready", vec_t'(instr_ready), vec_t'(1'b1));
    for (int i = 0; i < 16; i++) read_chk("post_rst_reg", 4'(i), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bfpu_ctrl.md
Name: bfpu_ctrl

Overview:
- Sequencer and operand store that drives a bit-vector functional unit (bfpu) and collects its results.
- Holds a small bit-vector register file and accepts one instruction at a time: opcode, choice, two source registers, one destination.
- Reads both operands, presents them to bfpu with both operand valids, waits for bfpu's registered result, then writes it back to the destination register.
- Sits between the host/loader and bfpu; bfpu shares clk/rst.

Parameters:
- BIT_VEC_SIZE, 256, width of every operand, result and register.
- NUM_REGS, 16, register file depth.
- REG_ADDR_W, 4, register address width; must equal clog2(NUM_REGS).
- TIMEOUT, 15, max cycles in WAIT before abort; 1..255.

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  high only in IDLE
- instr_opcode  in  3  000 select, 001 OR, 010 AND, 011 ANDN (src1&~src2), 100 XOR; 101-111 illegal
- instr_choice  in  1  select operand for opcode 000 (0=src1, 1=src2)
- instr_src1  in  REG_ADDR_W  source register 1
- instr_src2  in  REG_ADDR_W  source register 2
- instr_dst  in  REG_ADDR_W  destination register
- wr_en  in  1  host register write
- wr_addr  in  REG_ADDR_W  host write address
- wr_data  in  BIT_VEC_SIZE  host write data
- rd_addr  in  REG_ADDR_W  host read address
- rd_data  out  BIT_VEC_SIZE  registered read data, 1-cycle latency
- bfpu_in_1  out  BIT_VEC_SIZE  operand 1 to bfpu
- bfpu_valid_in_1  out  1  operand 1 valid
- bfpu_in_2  out  BIT_VEC_SIZE  operand 2 to bfpu
- bfpu_valid_in_2  out  1  operand 2 valid
- bfpu_opcode  out  3  opcode to bfpu
- bfpu_choice  out  1  choice to bfpu
- bfpu_out  in  BIT_VEC_SIZE  bfpu result
- bfpu_valid_out  in  1  bfpu result valid
- busy  out  1  high in ISSUE/WAIT
- done  out  1  one-cycle pulse after writeback
- err  out  1  one-cycle pulse: illegal opcode or timeout

Behaviour:
- Reset (sync, active-high):
  - State returns to IDLE; all registers cleared to 0.
  - rd_data, bfpu_in_1/2, bfpu_opcode, bfpu_choice, bfpu_valid_in_1/2, busy, done and err go to 0.
  - instr_ready is 0 while rst is high.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready with a legal opcode (cycle T): latch regs[src1], regs[src2], opcode and choice into the bfpu_* output registers and latch dst; go to ISSUE.
  - Illegal opcode: the handshake completes, err=1 in T+1, no issue, stay in IDLE.
- ISSUE (T+1):
  - bfpu_valid_in_1=bfpu_valid_in_2=1 for exactly this cycle; go to WAIT.
  - Operands are the values at acceptance; later host writes to the sources do not change them.
- WAIT:
  - Timeout counter starts at 0 on entry and increments each cycle.
  - On bfpu_valid_out=1: regs[dst]<=bfpu_out at that edge, done=1 next cycle, go to IDLE. Nominal: valid_out in T+2, done in T+3, next accept at T+3; throughput 1 instruction per 3 cycles.
  - If the counter reaches TIMEOUT without valid_out: err=1 next cycle, no writeback, go to IDLE.
- bfpu_valid_out outside WAIT is ignored.
- bfpu_opcode, bfpu_choice and bfpu_in_* hold their last values after ISSUE; only the valids drop.
- Host writes:
  - Honoured in every state.
  - Same-edge collision with writeback to the same address: the writeback wins and the host write is dropped.
  - Different addresses: both take effect.
- Reads: rd_data <= regs[rd_addr] every cycle, reflecting the register contents before that edge's writes (read-old).
- src1==src2 and dst==src are legal; dst is overwritten only at writeback.
- Reset mid-operation (ISSUE or WAIT): abandon with no writeback and no done/err; bfpu is reset by the same rst.
- busy=1 exactly while in ISSUE or WAIT; done and err are never high in the same cycle.

Test Plan:
- Load r1=0xF0F0, r2=0xFF00 (upper bits 0). Issue OR/AND/ANDN/XOR with dst=r3, reading r3 after each done -> 0xFFF0, 0xF000, 0x00F0, 0x0FF0. done pulses at T+3; instr_ready=0 during T+1..T+2.
- Issue opcode 000 with choice=0 then choice=1, src1=r1, src2=r2 -> r3=0xF0F0, then r3=0xFF00.
- Issue opcode 101 -> err pulse at T+1, no bfpu valids, registers unchanged, instr_ready stays 1.
- Tie bfpu_valid_out=0 -> err pulse after TIMEOUT=15 cycles in WAIT, dst unchanged, return to IDLE.
- Host wr_en to r3 (0x1234) on the same edge as the writeback to r3 (0xFFF0) -> r3=0xFFF0. A host write to r1 during WAIT takes effect and does not alter the result.
- Assert rst in WAIT -> no writeback, no done, all outputs 0 next cycle, registers 0.
